// File: rtl/priority_codec_pkg.sv
// Types and helpers shared by the priority encoder/decoder pair and their benches.
package priority_codec_pkg;

  localparam int MAX_CODE_W = 8;
  localparam int MAX_WIDTH  = 1 << MAX_CODE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Code field is sized for the widest supported decoder; narrower users zero-extend.
  typedef struct packed {
    logic                  none;
    logic [MAX_CODE_W-1:0] code;
  } entry_t;

  function automatic logic [MAX_WIDTH-1:0] onehot(input logic [MAX_CODE_W-1:0] code);
    logic [MAX_WIDTH-1:0] vec;
    vec       = '0;
    vec[code] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/priority_code_decoder_sync_fifo.sv
// Small synchronous FIFO with occupancy count; write is refused when full, read when empty.
module sync_fifo
  import priority_codec_pkg::*;
#(
  parameter  int WIDTH   = 4,
  parameter  int DEPTH   = 4,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int COUNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               pop,
  output logic [WIDTH-1:0]   rdata,
  output logic [COUNT_W-1:0] count,
  output logic               full,
  output logic               empty
);

  localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(DEPTH);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               do_push;
  logic               do_pop;

  // Fullness is judged on registered occupancy, so a same-cycle pop never frees room for a push.
  always_comb begin
    do_push  = push && (count_q != FULL_COUNT);
    do_pop   = pop && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + COUNT_W'(1);
      2'b01:   count_d = count_q - COUNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);

endmodule

// File: rtl/priority_code_decoder.sv
// Replays queued priority codes as one-hot strobes held HOLD_CYCLES clocks, separated by
// GAP_CYCLES all-zero clocks so that repeated codes stay distinguishable.
module priority_code_decoder
  import priority_codec_pkg::*;
#(
  parameter  int WIDTH       = 8,
  parameter  int DEPTH       = 4,
  parameter  int HOLD_CYCLES = 4,
  parameter  int GAP_CYCLES  = 1,
  localparam int CODE_W      = $clog2(WIDTH),
  localparam int COUNT_W     = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CODE_W-1:0]  in_code,
  input  logic               in_none,
  output logic [WIDTH-1:0]   out_onehot,
  output logic               out_valid,
  output logic               busy,
  output logic [COUNT_W-1:0] fifo_count
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int FIFO_W  = CODE_W + 1;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  entry_t             hold_q, hold_d;
  logic [WIDTH-1:0]   onehot_q, onehot_d;
  logic               valid_q, valid_d;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FIFO_W-1:0]  fifo_head;
  logic [COUNT_W-1:0] fifo_cnt;
  entry_t             head_entry;

  assign fifo_push = in_valid && !fifo_full;

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({in_none, in_code}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    head_entry      = '0;
    head_entry.none = fifo_head[CODE_W];
    head_entry.code = MAX_CODE_W'(fifo_head[CODE_W-1:0]);
  end

  // A symbol ends either into GAP or, with no gap configured, straight into the next symbol.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    fifo_pop = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          hold_d   = head_entry;
          cnt_d    = HOLD_LOAD;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (GAP_CYCLES > 0) begin
          cnt_d   = GAP_LOAD;
          state_d = GAP;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          hold_d   = head_entry;
          cnt_d    = HOLD_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          hold_d   = head_entry;
          cnt_d    = HOLD_LOAD;
          state_d  = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    valid_d  = (state_d == HOLD);
    onehot_d = (valid_d && !hold_d.none) ? WIDTH'(onehot(hold_d.code)) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hold_q   <= '0;
      onehot_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      onehot_q <= onehot_d;
      valid_q  <= valid_d;
    end
  end

  assign out_onehot = onehot_q;
  assign out_valid  = valid_q;
  assign in_ready   = !fifo_full;
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign fifo_count = fifo_cnt;

endmodule

// File: tb/tb_priority_code_decoder.sv
// Directed and randomised checks of priority_code_decoder against a symbol-timeline model,
// using one instance with a gap and one back-to-back instance.
module tb_priority_code_decoder;

  localparam int WIDTH   = 8;
  localparam int CODE_W  = 3;
  localparam int DEPTH   = 4;
  localparam int COUNT_W = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_a, in_valid_a, in_ready_a, in_none_a, out_valid_a, busy_a;
  logic [CODE_W-1:0]  in_code_a;
  logic [WIDTH-1:0]   out_onehot_a;
  logic [COUNT_W-1:0] fifo_count_a;

  logic               rst_b, in_valid_b, in_ready_b, in_none_b, out_valid_b, busy_b;
  logic [CODE_W-1:0]  in_code_b;
  logic [WIDTH-1:0]   out_onehot_b;
  logic [COUNT_W-1:0] fifo_count_b;

  priority_code_decoder #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD_CYCLES(4), .GAP_CYCLES(1)
  ) dut_a (
    .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_code(in_code_a), .in_none(in_none_a), .out_onehot(out_onehot_a),
    .out_valid(out_valid_a), .busy(busy_a), .fifo_count(fifo_count_a)
  );

  priority_code_decoder #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD_CYCLES(1), .GAP_CYCLES(0)
  ) dut_b (
    .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_code(in_code_b), .in_none(in_none_b), .out_onehot(out_onehot_b),
    .out_valid(out_valid_b), .busy(busy_b), .fifo_count(fifo_count_b)
  );

  // Each accepted symbol gets its start edge fixed at acceptance time.
  typedef struct {
    int start;
    bit none;
    int code;
  } sym_t;

  sym_t syms[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   sel = 0;
  int   hold_c = 4;
  int   gap_c = 1;
  int   last_start = 0;
  bit   have_last = 1'b0;
  bit   mdl_ready = 1'b1;
  bit   accepted = 1'b0;
  int   exp_onehot, exp_count;
  bit   exp_valid, exp_busy;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s dut=%0d cycle=%0d got=%0h expected=%0h", tag, sel, cyc, got, exp);
    end
  endtask

  task automatic modelEdge(input bit r, input bit v, input bit none, input int code);
    sym_t s;
    int   active;
    cyc++;
    accepted = 1'b0;
    if (r) begin
      syms.delete();
      have_last = 1'b0;
    end else if (v && mdl_ready) begin
      s.start = cyc + 1;
      if (have_last && (last_start + hold_c + gap_c > s.start))
        s.start = last_start + hold_c + gap_c;
      s.none = none;
      s.code = code;
      syms.push_back(s);
      last_start = s.start;
      have_last  = 1'b1;
      accepted   = 1'b1;
    end
    while (syms.size() > 0 && syms[0].start + hold_c + gap_c < cyc)
      void'(syms.pop_front());

    exp_valid  = 1'b0;
    exp_onehot = 0;
    exp_count  = 0;
    active     = 0;
    foreach (syms[i]) begin
      if (syms[i].start <= cyc && cyc < syms[i].start + hold_c) begin
        exp_valid = 1'b1;
        if (!syms[i].none) exp_onehot = 1 << syms[i].code;
      end
      if (syms[i].start <= cyc && cyc < syms[i].start + hold_c + gap_c) active++;
      if (syms[i].start > cyc) exp_count++;
    end
    exp_busy  = (active > 0) || (exp_count > 0);
    mdl_ready = (exp_count < DEPTH);
  endtask

  task automatic compareAll();
    logic [WIDTH-1:0]   oh;
    logic               ov, ob, ordy;
    logic [COUNT_W-1:0] oc;
    if (sel == 0) begin
      oh = out_onehot_a; ov = out_valid_a; ob = busy_a; ordy = in_ready_a; oc = fifo_count_a;
    end else begin
      oh = out_onehot_b; ov = out_valid_b; ob = busy_b; ordy = in_ready_b; oc = fifo_count_b;
    end
    checkOutput("out_onehot", 32'(oh), 32'(exp_onehot));
    checkOutput("out_valid", 32'(ov), 32'(exp_valid));
    checkOutput("busy", 32'(ob), 32'(exp_busy));
    checkOutput("fifo_count", 32'(oc), 32'(exp_count));
    checkOutput("in_ready", 32'(ordy), 32'(mdl_ready));
  endtask

  task automatic applyStimulus(input bit r, input bit v, input bit none, input int code);
    @(negedge clk);
    if (sel == 0) begin
      rst_a = r; in_valid_a = v; in_none_a = none; in_code_a = CODE_W'(code);
    end else begin
      rst_b = r; in_valid_b = v; in_none_b = none; in_code_b = CODE_W'(code);
    end
    @(posedge clk);
    modelEdge(r, v, none, code);
    #1;
    compareAll();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    rst_b = 1'b1; in_valid_b = 1'b0; in_none_b = 1'b0; in_code_b = '0;
    rst_a = 1'b1; in_valid_a = 1'b0; in_none_a = 1'b0; in_code_a = '0;

    // Instance A: HOLD=4, GAP=1.
    sel = 0; hold_c = 4; gap_c = 1;
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 2);

    applyStimulus(1'b0, 1'b1, 1'b0, 5);
    idleCycles(8);

    begin
      int idx = 0;
      for (int n = 0; n < 60 && idx < 6; n++) begin
        applyStimulus(1'b0, 1'b1, 1'b0, idx);
        if (accepted) idx++;
      end
    end
    idleCycles(40);

    applyStimulus(1'b0, 1'b1, 1'b0, 3);
    applyStimulus(1'b0, 1'b1, 1'b0, 3);
    idleCycles(14);

    applyStimulus(1'b0, 1'b1, 1'b1, 7);
    idleCycles(8);

    // Reset lands in the second hold clock of the second symbol with three entries queued.
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, i + 2);
    idleCycles(3);
    applyStimulus(1'b1, 1'b1, 1'b0, 6);
    idleCycles(12);

    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 7) == 0), int'($urandom_range(0, 7)));
    end
    idleCycles(30);

    // Instance B: HOLD=1, GAP=0.
    @(negedge clk);
    rst_a = 1'b1; in_valid_a = 1'b0;
    sel = 1; hold_c = 1; gap_c = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, (i * 5) % 8);
    idleCycles(6);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 7) == 0), int'($urandom_range(0, 7)));
    end
    idleCycles(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
